philo_ring_arb: RTL



---
 rtl/philo_ring_arb.sv | 93 +++++++++
 1 files changed

// File: rtl/philo_ring_arb.sv
// philo_ring_arb: parametrised dining-philosophers ring with fork ownership, fork fairness, bounded meals and hunger counters
//   clock      rising-edge clock
//   reset      synchronous active-high reset
//   coin       per-philosopher nondeterministic choice (coin[i] for philosopher i)
//   state      state[2i+1:2i] = philosopher i: 0 THINK, 1 HUNGRY, 2 EATING
//   fork_busy  fork i held by an EATING neighbour
//   fork_pri   fork i priority: 0 favours philosopher i, 1 favours philosopher (i+1)%N
//   starve     hunger counter of philosopher i saturated
// Optional: define PHILO_STARVE_BOOST_EN so a starving philosopher wins contested forks.
module philo_ring_arb #(
  parameter int N        = 8,
  parameter int EAT_MAX  = 3,
  parameter int STARVE_W = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   coin,
  output logic [2*N-1:0] state,
  output logic [N-1:0]   fork_busy,
  output logic [N-1:0]   fork_pri,
  output logic [N-1:0]   starve
);
  localparam logic [1:0] THINK = 2'd0, HUNGRY = 2'd1, EATING = 2'd2;
  localparam logic [3:0] EAT_LAST = 4'(EAT_MAX - 1);
  localparam logic [STARVE_W-1:0] HMAX = '1;
  logic [1:0]          st       [N];
  logic [1:0]          st_nxt   [N];
  logic [3:0]          eat_cnt  [N];
  logic [3:0]          eat_nxt  [N];
  logic [STARVE_W-1:0] hcnt     [N];
  logic [STARVE_W-1:0] hcnt_nxt [N];
  logic [N-1:0] hungry, eating, leave, base, grant, pri_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      st       <= '{default: THINK};
      eat_cnt  <= '{default: '0};
      hcnt     <= '{default: '0};
      fork_pri <= '0;
    end else begin
      st       <= st_nxt;
      eat_cnt  <= eat_nxt;
      hcnt     <= hcnt_nxt;
      fork_pri <= pri_nxt;
    end
  end

  // Philosopher i holds fork i (right, shared with R) and fork L (left, shared with L).
  // The two contenders of a fork always see complementary win_r/win_l, so neighbours
  // are never granted together.
  for (genvar i = 0; i < N; i++) begin : g_ph
    localparam int R = (i + 1) % N;
    localparam int L = (i + N - 1) % N;
    logic win_r, win_l;
`ifdef PHILO_STARVE_BOOST_EN
    assign win_r = (starve[i] != starve[R]) ? starve[i] : !fork_pri[i];
    assign win_l = (starve[i] != starve[L]) ? starve[i] : fork_pri[L];
`else
    assign win_r = !fork_pri[i];
    assign win_l = fork_pri[L];
`endif
    assign base[i] = hungry[i] && !eating[R] && !eating[L] && (!hungry[R] || win_r) && (!hungry[L] || win_l);
  end

  // With every philosopher hungry the priorities can point round the ring (e.g. all 0
  // after reset) and nobody wins both forks; when nothing is eating and nothing is
  // granted, the lowest-index hungry philosopher takes its (free) forks.
  assign grant = (|base || |eating) ? base : hungry & (~hungry + N'(1));

  always_comb begin
    for (int i = 0; i < N; i++) begin
      leave[i]    = eating[i] && (coin[i] || eat_cnt[i] == EAT_LAST);
      st_nxt[i]   = (st[i] == THINK)  ? (coin[i] ? THINK : HUNGRY) :
                    (st[i] == HUNGRY) ? (grant[i] ? EATING : HUNGRY) :
                    (eating[i] && !leave[i]) ? EATING : THINK;
      eat_nxt[i]  = (eating[i] && !leave[i]) ? eat_cnt[i] + 4'd1 : 4'd0;
      hcnt_nxt[i] = (hungry[i] && !grant[i]) ? ((hcnt[i] == HMAX) ? HMAX : hcnt[i] + STARVE_W'(1)) : '0;
    end
    for (int j = 0; j < N; j++)
      pri_nxt[j] = leave[j] ? 1'b1 : leave[(j + 1) % N] ? 1'b0 : fork_pri[j];
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      state[2*i +: 2] = st[i];
      hungry[i]       = st[i] == HUNGRY;
      eating[i]       = st[i] == EATING;
      starve[i]       = hcnt[i] == HMAX;
    end
  end

  assign fork_busy = eating | {eating[0], eating[N-1:1]};
endmodule
